// File: rtl/float32_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : float32_subtractor
//  Description : Pipelined IEEE 754 binary32 subtractor, res = a - b.
//                Round-to-nearest-even, subnormal inputs and results flushed
//                to signed zero, NaN results canonicalised to 32'h7FC00000.
//                One operation accepted per clock, no backpressure.
//                An op sampled at edge N is presented after edge N+3.
//  Ports       : clk       - rising-edge clock
//                rst_n     - asynchronous active-low reset
//                in_valid  - a/b valid this cycle
//                a         - minuend, binary32
//                b         - subtrahend, binary32
//                out_valid - one-cycle pulse per accepted op
//                res       - a - b, binary32 (held while out_valid=0)
//  Revision    : 1.0 - initial release
// ============================================================================
module float32_subtractor (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] res
);

   localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

   // ------------------------------------------------------------------------
   // S1: unpack, classify, swap, align
   // ------------------------------------------------------------------------
   logic        w_sa, w_sb;
   logic        w_a_zero, w_b_zero, w_a_nan, w_b_nan, w_a_inf, w_b_inf;
   logic [30:0] w_mag_a, w_mag_b;
   logic        w_a_ge;
   logic [23:0] w_sig_a, w_sig_b, w_sig_l, w_sig_s;
   logic [7:0]  w_exp_a, w_exp_b, w_exp_l, w_exp_s, w_diff;
   logic        w_sign_l;
   logic [26:0] w_ms_ext, w_aligned;
   logic        w_special;
   logic [31:0] w_spec_val;

   // b's sign is inverted up front so the rest is an ordinary addition
   assign w_sa     = a[31];
   assign w_sb     = ~b[31];
   assign w_a_zero = (a[30:23] == 8'd0);
   assign w_b_zero = (b[30:23] == 8'd0);
   assign w_a_nan  = (a[30:23] == 8'hFF) &&  (|a[22:0]);
   assign w_b_nan  = (b[30:23] == 8'hFF) &&  (|b[22:0]);
   assign w_a_inf  = (a[30:23] == 8'hFF) && !(|a[22:0]);
   assign w_b_inf  = (b[30:23] == 8'hFF) && !(|b[22:0]);

   // Subnormals (exponent 0) collapse to a zero magnitude
   assign w_mag_a  = w_a_zero ? 31'd0 : a[30:0];
   assign w_mag_b  = w_b_zero ? 31'd0 : b[30:0];
   assign w_a_ge   = (w_mag_a >= w_mag_b);

   assign w_sig_a  = w_a_zero ? 24'd0 : {1'b1, a[22:0]};
   assign w_sig_b  = w_b_zero ? 24'd0 : {1'b1, b[22:0]};
   assign w_exp_a  = w_mag_a[30:23];
   assign w_exp_b  = w_mag_b[30:23];

   assign w_sig_l  = w_a_ge ? w_sig_a : w_sig_b;
   assign w_sig_s  = w_a_ge ? w_sig_b : w_sig_a;
   assign w_exp_l  = w_a_ge ? w_exp_a : w_exp_b;
   assign w_exp_s  = w_a_ge ? w_exp_b : w_exp_a;
   assign w_sign_l = w_a_ge ? w_sa    : w_sb;
   assign w_diff   = w_exp_l - w_exp_s;
   assign w_ms_ext = {w_sig_s, 3'b000};

   // Align the smaller operand; everything shifted past the sticky position
   // is ORed back into bit 0.
   always_comb begin
      w_aligned = 27'd0;
      if (w_diff >= 8'd27) begin
         w_aligned = {26'd0, |w_sig_s};
      end else begin
         w_aligned = (w_ms_ext >> w_diff) |
                     {26'd0, |(w_ms_ext & ~({27{1'b1}} << w_diff))};
      end
   end

   always_comb begin
      w_special  = 1'b0;
      w_spec_val = 32'd0;
      if (w_a_nan || w_b_nan) begin
         w_special  = 1'b1;
         w_spec_val = C_QNAN;
      end else if (w_a_inf && w_b_inf) begin
         // Opposite effective signs means Inf - Inf of equal sign: invalid
         w_special  = 1'b1;
         w_spec_val = (w_sa != w_sb) ? C_QNAN : {w_sa, 8'hFF, 23'd0};
      end else if (w_a_inf) begin
         w_special  = 1'b1;
         w_spec_val = {w_sa, 8'hFF, 23'd0};
      end else if (w_b_inf) begin
         w_special  = 1'b1;
         w_spec_val = {w_sb, 8'hFF, 23'd0};
      end
   end

   logic        r1_valid, r1_special, r1_sign, r1_sub, r1_zsign;
   logic [31:0] r1_spec_val;
   logic [7:0]  r1_exp;
   logic [26:0] r1_ml, r1_ms;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid    <= 1'b0;
         r1_special  <= 1'b0;
         r1_sign     <= 1'b0;
         r1_sub      <= 1'b0;
         r1_zsign    <= 1'b0;
         r1_spec_val <= 32'd0;
         r1_exp      <= 8'd0;
         r1_ml       <= 27'd0;
         r1_ms       <= 27'd0;
      end else begin
         r1_valid <= in_valid;
         if (in_valid) begin
            r1_special  <= w_special;
            r1_spec_val <= w_spec_val;
            r1_sign     <= w_sign_l;
            r1_sub      <= w_sa ^ w_sb;
            // Exact-zero sign: negative only when both addends are negative
            r1_zsign    <= w_sa & w_sb;
            r1_exp      <= w_exp_l;
            r1_ml       <= {w_sig_l, 3'b000};
            r1_ms       <= w_aligned;
         end
      end
   end

   // ------------------------------------------------------------------------
   // S2: add / subtract (larger - smaller never goes negative)
   // ------------------------------------------------------------------------
   logic [27:0] w_sum;
   assign w_sum = r1_sub ? ({1'b0, r1_ml} - {1'b0, r1_ms})
                         : ({1'b0, r1_ml} + {1'b0, r1_ms});

   logic        r2_valid, r2_special, r2_sign, r2_zsign;
   logic [31:0] r2_spec_val;
   logic [7:0]  r2_exp;
   logic [27:0] r2_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_valid    <= 1'b0;
         r2_special  <= 1'b0;
         r2_sign     <= 1'b0;
         r2_zsign    <= 1'b0;
         r2_spec_val <= 32'd0;
         r2_exp      <= 8'd0;
         r2_sum      <= 28'd0;
      end else begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_special  <= r1_special;
            r2_spec_val <= r1_spec_val;
            r2_sign     <= r1_sign;
            r2_zsign    <= r1_zsign;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
         end
      end
   end

   // ------------------------------------------------------------------------
   // S3a: normalize
   // ------------------------------------------------------------------------
   logic [4:0]        w_lz;
   logic              w_found;
   logic [26:0]       w_norm_m;
   logic signed [9:0] w_norm_exp;
   logic [9:0]        w_exp_ext;

   always_comb begin
      w_lz    = 5'd0;
      w_found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!w_found && r2_sum[i]) begin
            w_lz    = 5'(26 - i);
            w_found = 1'b1;
         end
      end
   end

   assign w_exp_ext = {2'b00, r2_exp};

   always_comb begin
      if (r2_sum[27]) begin
         // Carry-out: shift right, dropped bit folds into sticky
         w_norm_m   = {r2_sum[27:2], r2_sum[1] | r2_sum[0]};
         w_norm_exp = w_exp_ext + 10'd1;
      end else begin
         w_norm_m   = r2_sum[26:0] << w_lz;
         w_norm_exp = w_exp_ext - {5'd0, w_lz};
      end
   end

   logic              r3_valid, r3_special, r3_sign, r3_zsign, r3_zero;
   logic [31:0]       r3_spec_val;
   logic signed [9:0] r3_exp;
   logic [26:0]       r3_m;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r3_valid    <= 1'b0;
         r3_special  <= 1'b0;
         r3_sign     <= 1'b0;
         r3_zsign    <= 1'b0;
         r3_zero     <= 1'b0;
         r3_spec_val <= 32'd0;
         r3_exp      <= 10'sd0;
         r3_m        <= 27'd0;
      end else begin
         r3_valid <= r2_valid;
         if (r2_valid) begin
            r3_special  <= r2_special;
            r3_spec_val <= r2_spec_val;
            r3_sign     <= r2_sign;
            r3_zsign    <= r2_zsign;
            r3_zero     <= (r2_sum == 28'd0);
            r3_exp      <= w_norm_exp;
            r3_m        <= w_norm_m;
         end
      end
   end

   // ------------------------------------------------------------------------
   // S3b: round (RNE), range check, pack
   // ------------------------------------------------------------------------
   logic              w_round_up;
   logic [24:0]       w_rnd;
   logic signed [9:0] w_exp_r;
   logic [22:0]       w_frac;
   logic [31:0]       w_res;

   // m[26:3] = significand, m[2] = guard, m[1] = round, m[0] = sticky
   assign w_round_up = r3_m[2] & (r3_m[1] | r3_m[0] | r3_m[3]);
   assign w_rnd      = {1'b0, r3_m[26:3]} + {24'd0, w_round_up};
   assign w_exp_r    = r3_exp + {9'd0, w_rnd[24]};
   assign w_frac     = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];

   always_comb begin
      if (r3_special) begin
         w_res = r3_spec_val;
      end else if (r3_zero) begin
         w_res = {r3_zsign, 31'd0};
      end else if (r3_exp < 10'sd1) begin
         w_res = {r3_sign, 31'd0};
      end else if (w_exp_r >= 10'sd255) begin
         w_res = {r3_sign, 8'hFF, 23'd0};
      end else begin
         w_res = {r3_sign, w_exp_r[7:0], w_frac};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         res       <= 32'd0;
      end else begin
         out_valid <= r3_valid;
         if (r3_valid) begin
            res <= w_res;
         end
      end
   end

endmodule
`default_nettype wire
